// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: shared constants for the serial front end and the
// 1101 detector path.
//   state_t          - serializer FSM encoding (ST_IDLE=0, ST_SHIFT=1)
//   DEFAULT_W        - default word width
//   DEFAULT_IDLE_BIT - line level when no bit is valid; 0 parks the detector
package bit_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int   DEFAULT_W        = 8;
  localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/bit_serializer_if.sv
// bit_serializer_if: word input handshake plus serial output bundle.
//   din/din_valid/din_ready - W-bit word handshake (upstream is master)
//   out/out_valid           - serial bit stream toward the detector
//   busy/word_done          - status: shifting / last bit of a word on out
interface bit_serializer_if #(
  parameter int W = bit_serializer_pkg::DEFAULT_W
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         out;
  logic         out_valid;
  logic         busy;
  logic         word_done;

  modport master (
    output din, din_valid,
    input  din_ready, out, out_valid, busy, word_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, out, out_valid, busy, word_done
  );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial converter, one bit per clock.
//   clk   - system clock
//   reset - synchronous, active-high; drops in-flight and held words
//   bus   - bit_serializer_if.slave (word handshake in, serial stream out)
// A one-word holding register lets the next word be accepted while the
// current one shifts out, so consecutive words stream with no gap.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   W         = DEFAULT_W,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);

  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state, state_d;
  logic [W-1:0]  sh, sh_d;
  logic [W-1:0]  hold, hold_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          hold_full, hold_full_d;
  logic          accept;
  logic [W-1:0]  sh_next;

  // Ready never depends on the last-bit transfer, only on hold occupancy.
  assign bus.din_ready = !reset && !hold_full;
  assign accept        = bus.din_valid && bus.din_ready;

  // Shift toward the output end; the vacated bit fills with 0.
  assign sh_next = MSB_FIRST ? {sh[W-2:0], 1'b0} : {1'b0, sh[W-1:1]};

  assign bus.busy      = (state == ST_SHIFT);
  assign bus.out_valid = (state == ST_SHIFT);
  assign bus.out       = (state == ST_SHIFT) ? (MSB_FIRST ? sh[W-1] : sh[0]) : IDLE_BIT;
  assign bus.word_done = (state == ST_SHIFT) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sh        <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_d;
      sh        <= sh_d;
      hold      <= hold_d;
      cnt       <= cnt_d;
      hold_full <= hold_full_d;
    end
  end

  always_comb begin
    state_d     = state;
    sh_d        = sh;
    hold_d      = hold;
    cnt_d       = cnt;
    hold_full_d = hold_full;
    case (state)
      ST_IDLE: begin
        // hold is always empty here, so an accept goes straight to sh.
        if (accept) begin
          sh_d    = bus.din;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt != LAST) begin
          sh_d  = sh_next;
          cnt_d = cnt + 1'b1;
          if (accept) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
          end
        end else if (hold_full) begin
          sh_d        = hold;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else if (accept) begin
          // Word arriving on the last-bit cycle bypasses hold entirely.
          sh_d  = bus.din;
          cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bit_serializer_if #(.W(8)) bm ();
  bit_serializer_if #(.W(8)) bl ();

  bit_serializer #(.W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .bus(bm)
  );
  bit_serializer #(.W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .bus(bl)
  );

  // Minimal registered 1101 detector attached to each serial output.
  logic [3:0] hm, hl;
  logic       chk_m, chk_l;
  always_ff @(posedge clk) begin
    if (reset) begin
      hm <= '0;
      hl <= '0;
    end else begin
      hm <= {hm[2:0], bm.out};
      hl <= {hl[2:0], bl.out};
    end
  end
  assign chk_m = (hm == 4'b1101);
  assign chk_l = (hl == 4'b1101);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bm.din = '0; bm.din_valid = 1'b0;
    bl.din = '0; bl.din_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bm.din_ready !== 1'b0) begin
        n_err++; $display("FAIL reset_ready cyc%0d got %b want 0", c, bm.din_ready);
      end
      n_cmp++;
      if (bl.din_ready !== 1'b0) begin
        n_err++; $display("FAIL reset_ready_lsb cyc%0d got %b want 0", c, bl.din_ready);
      end
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bm.out, bm.out_valid, bm.busy, bm.word_done, bm.din_ready} !== 5'b00001) begin
      n_err++;
      $display("FAIL post_reset out/vld/busy/done/rdy got %b%b%b%b%b want 00001",
               bm.out, bm.out_valid, bm.busy, bm.word_done, bm.din_ready);
    end
    tick();
  endtask

  task automatic test_single;
    logic [7:0] pat;
    pat = 8'hD0;
    bm.din = pat; bm.din_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bm.din_ready !== 1'b1) begin
      n_err++; $display("FAIL single_ready got %b want 1", bm.din_ready);
    end
    tick();
    bm.din_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bm.out_valid !== (c <= 8) || bm.busy !== (c <= 8)) begin
        n_err++; $display("FAIL single_vld cyc%0d got vld=%b busy=%b want %b", c, bm.out_valid, bm.busy, c <= 8);
      end
      n_cmp++;
      if (bm.out !== ((c <= 8) ? pat[8-c] : 1'b0)) begin
        n_err++; $display("FAIL single_out cyc%0d got %b want %b", c, bm.out, (c <= 8) ? pat[8-c] : 1'b0);
      end
      n_cmp++;
      if (bm.word_done !== (c == 8)) begin
        n_err++; $display("FAIL single_done cyc%0d got %b want %b", c, bm.word_done, c == 8);
      end
      n_cmp++;
      if (chk_m !== (c == 5)) begin
        n_err++; $display("FAIL single_check cyc%0d got %b want %b", c, chk_m, c == 5);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] pat;
    pat = 16'hAA55;
    bm.din = 8'hAA; bm.din_valid = 1'b1;
    tick();
    bm.din = 8'h55;
    for (int c = 1; c <= 17; c++) begin
      if (c == 9) bm.din_valid = 1'b0;
      @(negedge clk);
      if (c >= 2 && c <= 8) begin
        n_cmp++;
        if (bm.din_ready !== 1'b0) begin
          n_err++; $display("FAIL b2b_ready cyc%0d got %b want 0", c, bm.din_ready);
        end
      end
      n_cmp++;
      if (bm.out_valid !== (c <= 16)) begin
        n_err++; $display("FAIL b2b_vld cyc%0d got %b want %b", c, bm.out_valid, c <= 16);
      end
      n_cmp++;
      if (bm.out !== ((c <= 16) ? pat[16-c] : 1'b0)) begin
        n_err++; $display("FAIL b2b_out cyc%0d got %b want %b", c, bm.out, (c <= 16) ? pat[16-c] : 1'b0);
      end
      n_cmp++;
      if (bm.word_done !== (c == 8 || c == 16)) begin
        n_err++; $display("FAIL b2b_done cyc%0d got %b want %b", c, bm.word_done, c == 8 || c == 16);
      end
      tick();
    end
  endtask

  // second word first presented at cycle `first`; its bits start one cycle later
  task automatic test_second_word(input int first, input string tag);
    logic [15:0] pat;
    int          s;
    pat = 16'hD03C;
    bm.din = 8'hD0; bm.din_valid = 1'b1;
    tick();
    bm.din_valid = 1'b0;
    for (int c = 1; c <= first + 9; c++) begin
      if (c == first) begin
        bm.din = 8'h3C; bm.din_valid = 1'b1;
      end else if (c == first + 1) begin
        bm.din_valid = 1'b0;
      end
      @(negedge clk);
      s = (c <= 8) ? (8 - c) : (c > first && c <= first + 8) ? (first + 8 - c) : -1;
      n_cmp++;
      if (bm.out_valid !== (s >= 0)) begin
        n_err++; $display("FAIL %s_vld cyc%0d got %b want %b", tag, c, bm.out_valid, s >= 0);
      end
      n_cmp++;
      if (bm.out !== ((s < 0) ? 1'b0 : (c <= 8) ? pat[8+s] : pat[s])) begin
        n_err++; $display("FAIL %s_out cyc%0d got %b", tag, c, bm.out);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    bm.din = 8'hFF; bm.din_valid = 1'b1;
    tick();
    tick();
    bm.din_valid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (bm.din_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_holdfull_ready got %b want 0", bm.din_ready);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bm.din_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_ready got %b want 0", bm.din_ready);
    end
    tick();
    reset = 1'b0;
    for (int c = 5; c <= 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bm.out_valid !== 1'b0 || bm.out !== 1'b0) begin
        n_err++; $display("FAIL mid_flush cyc%0d got vld=%b out=%b want 0 0", c, bm.out_valid, bm.out);
      end
      if (c == 5) begin
        n_cmp++;
        if (bm.din_ready !== 1'b1) begin
          n_err++; $display("FAIL mid_ready_after cyc5 got %b want 1", bm.din_ready);
        end
      end
      tick();
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] exp_bits;
    exp_bits = 8'b11010000; // cycle1 .. cycle8, left to right
    bl.din = 8'h0B; bl.din_valid = 1'b1;
    tick();
    bl.din_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bl.out_valid !== (c <= 8)) begin
        n_err++; $display("FAIL lsb_vld cyc%0d got %b want %b", c, bl.out_valid, c <= 8);
      end
      n_cmp++;
      if (bl.out !== ((c <= 8) ? exp_bits[8-c] : 1'b0)) begin
        n_err++; $display("FAIL lsb_out cyc%0d got %b want %b", c, bl.out, (c <= 8) ? exp_bits[8-c] : 1'b0);
      end
      n_cmp++;
      if (chk_l !== (c == 5)) begin
        n_err++; $display("FAIL lsb_check cyc%0d got %b want %b", c, chk_l, c == 5);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    tick();
    test_back_to_back();
    test_second_word(8, "bypass");
    test_second_word(9, "late");
    test_reset_mid();
    test_lsb_first();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
